// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int LEN_W          = 16;
  localparam logic [BYTE_W-1:0] CHK_INIT = 8'h00;

  // Frame parser states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // A load is in progress in every state except the three resting ones.
  function automatic logic state_busy(input state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/ram_loader_timeout.sv
// Loadable up-counter with clear/enable; flags expiry once LIMIT is reached
// and saturates there.
module ram_loader_timeout #(
  parameter int WIDTH = 20,
  parameter int LIMIT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q >= LIM);

  // Next count: clear wins over load, load over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (load)            cnt_d = load_val;
    else if (en && !expired)  cnt_d = cnt_q + WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_loader.sv
// Boot loader: frames a byte stream into 16-bit big-endian words, writes them
// to RAM from BASE_ADDR, verifies an XOR checksum and holds the CPU meanwhile.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int          TO_W = $clog2(TIMEOUT + 1);
  // Words that fit between BASE_ADDR and the top of RAM.
  localparam logic [31:0] CAP  = 32'((1 << ADDR_W) - BASE_ADDR);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [BYTE_W-1:0]   chk_q, chk_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_in_q, ram_in_d;
  logic                ram_load_q, ram_load_d;

  logic                start_go, byte_go, expired;
  logic [LEN_W-1:0]    len_word, idx_nxt;

  assign busy        = state_busy(state_q);
  assign cpu_hold    = busy;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;

  assign start_go = start && !busy;
  assign byte_go  = rx_valid && busy;
  assign len_word = {len_q[LEN_W-1:BYTE_W], rx_data};
  assign idx_nxt  = idx_q + LEN_W'(1);

  // Inter-byte gap watchdog: restarted by start and by every accepted byte.
  ram_loader_timeout #(.WIDTH(TO_W), .LIMIT(TIMEOUT)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr      (start_go || byte_go),
    .en       (busy),
    .load     (1'b0),
    .load_val ('0),
    .expired  (expired)
  );

  // Frame parser next-state and RAM write port.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    hi_d          = hi_q;
    chk_d         = chk_q;
    ram_address_d = ram_address_q;
    ram_in_d      = ram_in_q;
    ram_load_d    = 1'b0;
    if (byte_go) chk_d = chk_q ^ rx_data;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          chk_d   = CHK_INIT;
          idx_d   = '0;
        end
      end
      S_LEN_HI: if (rx_valid) begin
        len_d   = {rx_data, len_q[BYTE_W-1:0]};
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (rx_valid) begin
        len_d = len_word;
        if (len_word == '0)              state_d = S_CHECK;
        else if (32'(len_word) > CAP)    state_d = S_ERR;
        else                             state_d = S_DATA_HI;
      end
      S_DATA_HI: if (rx_valid) begin
        hi_d    = rx_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (rx_valid) begin
        ram_in_d      = DATA_W'({hi_q, rx_data});
        ram_address_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
        ram_load_d    = 1'b1;
        idx_d         = idx_nxt;
        state_d       = (idx_nxt == len_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (rx_valid) begin
        state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    // A byte landing on the expiry cycle wins, so a word is never half-written.
    if (busy && !rx_valid && expired) begin
      state_d    = S_ERR;
      ram_load_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      hi_q          <= '0;
      chk_q         <= CHK_INIT;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      ram_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      hi_q          <= hi_d;
      chk_q         <= chk_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
      ram_load_q    <= ram_load_d;
    end
  end

endmodule
